// File: rtl/io_instruction_sequencer.sv
// CPU I/O instruction sequencer: turns SIO/TIO/TDV/HIO/AIO requests into IOP
// activity and owns the single shared IOP transfer slot.
module io_instruction_sequencer #(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] DEV_MASK       = 8'b0011_1110
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [0:2]   func,
    input  logic [21:31] device_addr,
    output logic         busy,
    output logic         done,
    output logic [0:1]   cc,
    output logic [21:31] int_device,
    output logic         iop_active,
    output logic [0:2]   iop_func,
    output logic [21:31] iop_device,
    input  logic [0:1]   iop_cc,
    input  logic         iop_done
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:2] F_SIO = 3'd0;
    localparam logic [0:2] F_TIO = 3'd1;
    localparam logic [0:2] F_TDV = 3'd2;
    localparam logic [0:2] F_HIO = 3'd3;
    localparam logic [0:2] F_AIO = 3'd6;

    localparam logic [0:1] CC_OK    = 2'b00;
    localparam logic [0:1] CC_BUSY  = 2'b01;
    localparam logic [0:1] CC_TMO   = 2'b10;
    localparam logic [0:1] CC_NODEV = 2'b11;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DECODE  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]       state;
    logic [0:2]       req_func;
    logic [21:31]     req_dev;
    logic             xfer;
    logic [CNT_W-1:0] tmo_cnt;
    logic             int_pending;
    logic [21:31]     int_addr;
    logic [0:1]       int_cc;

    logic [2:0]       dev_iop;
    logic [7:0]       dev_num;
    logic             dev_ok;
    logic             dev_match;
    logic [0:1]       dec_cc;
    logic             sio_go;
    logic             hio_kill;
    logic             aio_take;
    logic             done_evt;
    logic             tmo_evt;

    assign busy = (state != S_IDLE);
    assign done = (state == S_RESPOND);

    assign dev_iop   = req_dev[21:23];
    assign dev_num   = req_dev[24:31];
    assign dev_ok    = (dev_iop == 3'd0) && (dev_num[7:3] == 5'd0) && DEV_MASK[dev_num[2:0]];
    // iop_device doubles as busy_dev: it is only loaded when the slot is claimed
    assign dev_match = (req_dev == iop_device);

    always_comb begin
        dec_cc   = CC_NODEV;
        sio_go   = 1'b0;
        hio_kill = 1'b0;
        aio_take = 1'b0;
        case (req_func)
            F_SIO: begin
                if (!dev_ok)   dec_cc = CC_NODEV;
                else if (xfer) dec_cc = CC_BUSY;
                else begin
                    dec_cc = CC_OK;
                    sio_go = 1'b1;
                end
            end
            F_TIO, F_TDV: begin
                if (!dev_ok) dec_cc = CC_NODEV;
                else         dec_cc = (xfer && dev_match) ? CC_BUSY : CC_OK;
            end
            F_HIO: begin
                // a completion landing this same cycle beats the halt
                if (!dev_ok) dec_cc = CC_NODEV;
                else if (xfer && dev_match && !iop_done) begin
                    dec_cc   = CC_BUSY;
                    hio_kill = 1'b1;
                end else dec_cc = CC_OK;
            end
            F_AIO: begin
                if (int_pending) begin
                    dec_cc   = CC_OK;
                    aio_take = 1'b1;
                end else dec_cc = CC_NODEV;
            end
            default: dec_cc = CC_NODEV;
        endcase
        if (state != S_DECODE) begin
            sio_go   = 1'b0;
            hio_kill = 1'b0;
            aio_take = 1'b0;
        end
    end

    assign done_evt = xfer && iop_done;
    assign tmo_evt  = xfer && !iop_done && !hio_kill && (tmo_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            req_func    <= '0;
            req_dev     <= '0;
            cc          <= '0;
            int_device  <= '0;
            xfer        <= 1'b0;
            iop_active  <= 1'b0;
            iop_func    <= '0;
            iop_device  <= '0;
            tmo_cnt     <= '0;
            int_pending <= 1'b0;
            int_addr    <= '0;
            int_cc      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        req_func <= func;
                        req_dev  <= device_addr;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cc    <= dec_cc;
                    state <= S_RESPOND;
                end
                default: state <= S_IDLE;
            endcase

            if (aio_take) int_device <= int_addr;

            if (sio_go) begin
                xfer       <= 1'b1;
                iop_active <= 1'b1;
                iop_func   <= req_func;
                iop_device <= req_dev;
                tmo_cnt    <= '0;
            end else if (hio_kill || done_evt || tmo_evt) begin
                xfer       <= 1'b0;
                iop_active <= 1'b0;
            end else if (xfer && (tmo_cnt != CNT_LAST)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // a fresh completion overrides an AIO clear in the same cycle
            if (done_evt || tmo_evt) begin
                int_pending <= 1'b1;
                int_addr    <= iop_device;
                int_cc      <= done_evt ? iop_cc : CC_TMO;
            end else if (aio_take) begin
                int_pending <= 1'b0;
            end
        end
    end

    // completion cc is held for a status read path not wired out yet
    logic unused_int_cc;
    assign unused_int_cc = ^int_cc;

endmodule

// File: tb/tb_io_instruction_sequencer.sv
// Directed bench for io_instruction_sequencer; a monitor checks each done
// pulse against a queue of expected responses.
module tb_io_instruction_sequencer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [0:2]   func = '0;
    logic [21:31] device_addr = '0;
    logic         busy, done;
    logic [0:1]   cc;
    logic [21:31] int_device;
    logic         iop_active;
    logic [0:2]   iop_func;
    logic [21:31] iop_device;
    logic [0:1]   iop_cc = '0;
    logic         iop_done = 1'b0;

    io_instruction_sequencer #(.TIMEOUT_CYCLES(16), .DEV_MASK(8'b0011_1110)) dut (
        .clock(clock), .reset(reset), .start(start), .func(func),
        .device_addr(device_addr), .busy(busy), .done(done), .cc(cc),
        .int_device(int_device), .iop_active(iop_active), .iop_func(iop_func),
        .iop_device(iop_device), .iop_cc(iop_cc), .iop_done(iop_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [1:0] cc;
        logic [10:0] idev;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issued = 0;
    int   n_done   = 0;
    int   act_cycles = 0;
    logic [10:0] exp_int = '0;

    localparam logic [2:0] SIO = 3'd0, TIO = 3'd1, TDV = 3'd2, HIO = 3'd3, AIO = 3'd6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // issue one instruction; optionally strobe iop_done during its DECODE cycle
    task automatic issue(input string name, input logic [2:0] f, input logic [10:0] a,
                         input logic [1:0] exp_cc, input bit done_in_decode);
        exp_t e;
        int   n;
        e.name = name; e.cc = exp_cc; e.idev = exp_int;
        exp_q.push_back(e);
        n_issued++;
        start = 1'b1; func = f; device_addr = a;
        tick();
        start = 1'b0;
        iop_done = done_in_decode;
        check({name, "_lat1"}, done, 0);
        tick();
        iop_done = 1'b0;
        check({name, "_lat2"}, done, 1);
        n = 0;
        while (busy && n < 8) begin tick(); n++; end
        if (busy) check({name, "_busy_stuck"}, busy, 0);
    endtask

    task automatic pulse_iop_done(input logic [1:0] c);
        iop_cc = c; iop_done = 1'b1;
        tick();
        iop_done = 1'b0;
    endtask

    always @(negedge clock) begin
        if (iop_active) act_cycles++;
        if (!reset && done) begin
            n_done++;
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_cc"}, cc, e.cc);
                check({e.name, "_int_device"}, int_device, e.idev);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cc", cc, 0);
        check("rst_iop_active", iop_active, 0);
        check("rst_iop_device", iop_device, 0);
        check("rst_int_device", int_device, 0);
        tick();
        reset = 1'b0;
        tick();

        // basic SIO, completion, AIO
        issue("sio005", SIO, 11'h005, 2'b00, 0);
        check("t1_active", iop_active, 1);
        check("t1_iop_device", iop_device, 11'h005);
        check("t1_iop_func", iop_func, 0);
        repeat (8) tick();
        check("t1_active_pre", iop_active, 1);
        pulse_iop_done(2'b00);
        check("t1_active_off", iop_active, 0);
        exp_int = 11'h005;
        issue("aio_t1", AIO, 11'h000, 2'b00, 0);

        // slot occupied
        issue("sio005b", SIO, 11'h005, 2'b00, 0);
        issue("sio001_busy", SIO, 11'h001, 2'b01, 0);
        check("t2_iop_device", iop_device, 11'h005);
        issue("tio005", TIO, 11'h005, 2'b01, 0);
        issue("tio001", TIO, 11'h001, 2'b00, 0);
        issue("tdv005", TDV, 11'h005, 2'b01, 0);
        pulse_iop_done(2'b01);
        check("t2_active_off", iop_active, 0);
        issue("aio_t2", AIO, 11'h000, 2'b00, 0);

        // unrecognized devices
        issue("sio007", SIO, 11'h007, 2'b11, 0);
        issue("tio007", TIO, 11'h007, 2'b11, 0);
        issue("sio101", SIO, 11'h101, 2'b11, 0);
        issue("tio101", TIO, 11'h101, 2'b11, 0);
        issue("sio008", SIO, 11'h008, 2'b11, 0);
        issue("hio000", HIO, 11'h000, 2'b11, 0);
        check("t3_active", iop_active, 0);
        issue("aio_none", AIO, 11'h000, 2'b11, 0);

        // timeout
        act_cycles = 0;
        issue("sio003", SIO, 11'h003, 2'b00, 0);
        n = 0;
        while (iop_active && n < 40) begin tick(); n++; end
        check("tmo_active_off", iop_active, 0);
        check("tmo_active_cycles", act_cycles, 16);
        exp_int = 11'h003;
        issue("aio_tmo", AIO, 11'h000, 2'b00, 0);
        issue("aio_tmo2", AIO, 11'h000, 2'b11, 0);

        // HIO on busy device, then HIO racing a completion
        issue("sio004", SIO, 11'h004, 2'b00, 0);
        issue("hio004", HIO, 11'h004, 2'b01, 0);
        check("hio_active_off", iop_active, 0);
        issue("aio_hio", AIO, 11'h000, 2'b11, 0);
        issue("sio002", SIO, 11'h002, 2'b00, 0);
        issue("hio002_race", HIO, 11'h002, 2'b00, 1);
        check("race_active_off", iop_active, 0);
        exp_int = 11'h002;
        issue("aio_race", AIO, 11'h000, 2'b00, 0);

        // reset mid-transfer with an instruction in DECODE
        issue("sio001", SIO, 11'h001, 2'b00, 0);
        start = 1'b1; func = TIO; device_addr = 11'h001;
        tick();
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_active", iop_active, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        tick();
        reset = 1'b0;
        exp_int = '0;
        tick();
        issue("sio005_post", SIO, 11'h005, 2'b00, 0);
        check("post_active", iop_active, 1);

        // start held through the whole instruction: one done only
        exp_q.push_back('{name: "tio_held", cc: 2'b01, idev: exp_int});
        n_issued++;
        start = 1'b1; func = TIO; device_addr = 11'h005;
        repeat (3) tick();
        start = 1'b0;
        repeat (4) tick();
        check("done_count", n_done, n_issued);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
